dbus_sram_responder: RTL and testbench
======================================

// Module: dbus_sram_responder
// PURPOSE
//  Responder end of the data-bus protocol (dbus_req_t / dbus_resp_t from common) that the pipeline core initiates on.
//  Models a word-addressed, byte-strobed 64-bit SRAM with configurable access latency.
//  Sits in the simulation top in place of the real memory system, driving dresp back to the core's memory stage.
//  Loads return the full aligned 64-bit word; the core performs sub-word extraction.
// PARAMETERS
//  DEPTH    1024           number of 64-bit words (power of two)
//  LATENCY  2              cycles from request acceptance to data_ok (>=1)
//  BASE     64'h8000_0000  byte address mapped to word 0
// PORTS
//  clk    in   1    clock; single clock domain
//  reset  in   1    synchronous, active-high reset
//  dreq   in   dbus_req_t   valid, addr[63:0], size, strobe[7:0], data[63:0] from initiator
//  dresp  out  dbus_resp_t  addr_ok, data_ok, data[63:0] to initiator
// BEHAVIOUR
//  - Reset: state=IDLE, counter=0, dresp.addr_ok=0, dresp.data_ok=0, dresp.data=0.
//    SRAM contents are not reset.
//  - Protocol: the initiator holds valid and all request fields stable until it sees data_ok.
//    addr_ok and data_ok are asserted together for exactly one cycle per transaction.
//  - FSM IDLE -> BUSY -> RESP -> IDLE:
//    IDLE: valid=1 accepts the request. Latch addr, strobe and data; load cnt=LATENCY-1.
//          Go to RESP if LATENCY==1, else to BUSY.
//    BUSY: cnt decrements each cycle; go to RESP when cnt==1.
//          If valid drops, go to IDLE: no write, no response (abort).
//    RESP: addr_ok=data_ok=1 and data=mem[idx] (pre-write value); go to IDLE.
//  - Timing: a request accepted at cycle t sees data_ok at cycle t+LATENCY.
//    IDLE costs one cycle between back-to-back transactions, so the next acceptance is at t+LATENCY+1 at earliest.
//  - Index: idx = (addr-BASE)[$clog2(DEPTH)+2:3]. addr[2:0] and size are ignored by the responder.
//  - Out of range (addr<BASE or addr>=BASE+8*DEPTH): the response is still given, data=0, and any write is dropped.
//  - Write: strobe!=0 is a store. In the RESP cycle, for each i where strobe[i]=1, mem[idx] byte i <= data byte i.
//    Other bytes are unchanged. Store responses carry data=pre-write word (the initiator ignores it).
//  - strobe==0 is a load: SRAM is not written.
//  - dresp.data is 0 in every cycle other than RESP.
//    addr_ok and data_ok are never asserted outside RESP.
//  - Reset asserted in any state goes to IDLE on the next edge. A pending write is discarded and no response is issued.
//  - Outputs are registered from state only; no combinational path from dreq to dresp.
// STRUCTURE
//  - Package entries (common): MEM_BASE constant; typedef enum logic[1:0] {IDLE,BUSY,RESP} dsram_state_t.
//  - Sub-module sram_bank_64: DEPTH x 64 single-port array with 8 byte-enables.
//    Synchronous write, combinational read.
//  - Top: FSM, latency counter ($clog2(LATENCY+1) bits), request latch, range check.
// TESTING
//  1. LATENCY=2. Preload mem[0]=64'h1122_3344_5566_7788. Load addr=8000_0000 at t.
//     -> data_ok only at t+2, data=1122_3344_5566_7788.
//  2. Store addr=8000_0008, strobe=8'h0F, data=FFFF_FFFF_AAAA_BBBB over a word initially 0; then load the same address.
//     -> load returns 0000_0000_AAAA_BBBB.
//  3. Load addr=7FFF_FFF8 and load addr=BASE+8*DEPTH.
//     -> each gets data_ok with data=0. A store to the same address leaves every in-range word unchanged.
//  4. Two back-to-back loads, valid held high.
//     -> data_ok pulses are one cycle each, separated by LATENCY cycles; never two consecutive cycles high.
//  5. Store issued, then valid dropped in BUSY.
//     -> no data_ok; FSM returns to IDLE; target word unchanged.
//  6. Store accepted, reset pulsed during BUSY.
//     -> next cycle dresp all zero, state IDLE, word unchanged. LATENCY=1 run: data_ok at t+1.

Source files
------------

// File: rtl/dbus_sram_responder_pkg.sv
// Shared types and constants for the data-bus SRAM responder.
//
// Contents:
//   MEM_BASE      - byte address that maps to SRAM word 0
//   dsram_state_t - responder FSM state encoding
//   dbus_req_t    - request from the initiator (core memory stage)
//   dbus_resp_t   - response back to the initiator
//   dbus_in_range - range check of a byte address against a window of 64-bit words
package dbus_sram_responder_pkg;

  localparam logic [63:0] MEM_BASE = 64'h8000_0000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } dsram_state_t;

  typedef struct packed {
    logic        valid;
    logic [63:0] addr;
    logic [2:0]  size;
    logic [7:0]  strobe;
    logic [63:0] data;
  } dbus_req_t;

  typedef struct packed {
    logic        addr_ok;
    logic        data_ok;
    logic [63:0] data;
  } dbus_resp_t;

  // True when addr falls inside [base, base + 8*words). Working on the offset avoids overflow
  // of base + 8*words near the top of the address space.
  function automatic logic dbus_in_range(input logic [63:0] addr, input logic [63:0] base,
                                         input logic [63:0] words);
    logic [63:0] off;
    off = addr - base;
    return (addr >= base) && (off < (words << 3));
  endfunction

endpackage

// File: rtl/dbus_sram_responder_sram_bank_64.sv
// sram_bank_64: Depth x 64-bit single-port memory with per-byte write enables.
//
// Ports:
//   clk_i   - clock
//   we_i    - write enable; bytes selected by be_i are written at the rising edge
//   be_i    - byte enables, bit i covers data bits [8*i+7:8*i]
//   addr_i  - word address, shared by read and write
//   wdata_i - write data
//   rdata_o - combinational read data of mem[addr_i] (value before any write this cycle)
//
// Contents are not reset.
module sram_bank_64 #(
  parameter int unsigned Depth = 1024,
  localparam int unsigned AddrW = (Depth > 1) ? $clog2(Depth) : 1
) (
  input  logic             clk_i,
  input  logic             we_i,
  input  logic [7:0]       be_i,
  input  logic [AddrW-1:0] addr_i,
  input  logic [63:0]      wdata_i,
  output logic [63:0]      rdata_o
);

  logic [63:0] mem_q [Depth];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      for (int i = 0; i < 8; i++) begin
        if (be_i[i]) begin
          mem_q[addr_i][8*i +: 8] <= wdata_i[8*i +: 8];
        end
      end
    end
  end

  assign rdata_o = mem_q[addr_i];

endmodule

// File: rtl/dbus_sram_responder.sv
// dbus_sram_responder: responder end of the core's data bus, modelling a word-addressed,
// byte-strobed 64-bit SRAM with a fixed access latency.
//
// Parameters:
//   DEPTH   - number of 64-bit words (power of two, >= 2)
//   LATENCY - cycles from request acceptance to data_ok (>= 1)
//   BASE    - byte address mapped to word 0
//
// Ports:
//   clk   - clock, single domain
//   reset - synchronous, active-high reset
//   dreq  - request: valid, addr, size, strobe, data (held stable until data_ok)
//   dresp - response: addr_ok, data_ok (one-cycle pulse together), data
//
// Loads return the whole aligned word; addr[2:0] and size are ignored. strobe != 0 is a
// store; its response carries the pre-write word. Out-of-range accesses are answered with
// data 0 and never write. Dropping valid while BUSY aborts the transaction silently.
module dbus_sram_responder
  import dbus_sram_responder_pkg::*;
#(
  parameter int unsigned DEPTH   = 1024,
  parameter int unsigned LATENCY = 2,
  parameter logic [63:0] BASE    = MEM_BASE
) (
  input  logic       clk,
  input  logic       reset,
  input  dbus_req_t  dreq,
  output dbus_resp_t dresp
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned CntW = (LATENCY > 1) ? $clog2(LATENCY + 1) : 1;
  localparam logic [CntW-1:0] CntLoad = CntW'(LATENCY - 1);
  localparam logic [CntW-1:0] CntLast = CntW'(1);

  // Request decode (used only at acceptance)
  logic [63:0]     req_off;
  logic [IdxW-1:0] req_idx;
  logic            req_in_range;

  assign req_off      = dreq.addr - BASE;
  assign req_idx      = req_off[IdxW+2:3];
  assign req_in_range = dbus_in_range(dreq.addr, BASE, 64'(DEPTH));

  // State and latched request
  dsram_state_t    state_q;
  logic [CntW-1:0] cnt_q;
  logic [IdxW-1:0] idx_q;
  logic            in_range_q;
  logic [7:0]      strobe_q;
  logic [63:0]     wdata_q;
  dbus_resp_t      dresp_q;

  // Memory interface
  logic [IdxW-1:0] bank_addr;
  logic [63:0]     bank_rdata;
  logic            bank_we;

  // Response captured on entry to RESP
  logic            resp_hit;
  dbus_resp_t      resp_d;

  // With LATENCY == 1 the response is captured in the accept cycle itself, before the
  // request latch holds anything, so the bank is addressed straight from the request.
  assign bank_addr = (state_q == IDLE) ? req_idx : idx_q;
  assign resp_hit  = (state_q == IDLE) ? req_in_range : in_range_q;

  always_comb begin
    resp_d         = '0;
    resp_d.addr_ok = 1'b1;
    resp_d.data_ok = 1'b1;
    resp_d.data    = resp_hit ? bank_rdata : 64'd0;
  end

  // Store commits at the end of RESP; the response already holds the pre-write word.
  // Reset during RESP discards the write.
  assign bank_we = (state_q == RESP) && in_range_q && (strobe_q != 8'd0) && !reset;

  sram_bank_64 #(
    .Depth (DEPTH)
  ) u_bank (
    .clk_i   (clk),
    .we_i    (bank_we),
    .be_i    (strobe_q),
    .addr_i  (bank_addr),
    .wdata_i (wdata_q),
    .rdata_o (bank_rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      dresp_q <= '0;
    end else begin
      dresp_q <= '0;
      case (state_q)
        IDLE: begin
          if (dreq.valid) begin
            idx_q      <= req_idx;
            in_range_q <= req_in_range;
            strobe_q   <= dreq.strobe;
            wdata_q    <= dreq.data;
            cnt_q      <= CntLoad;
            if (LATENCY == 1) begin
              state_q <= RESP;
              dresp_q <= resp_d;
            end else begin
              state_q <= BUSY;
            end
          end
        end
        BUSY: begin
          // Abort wins over completion when valid drops on the last BUSY cycle
          if (!dreq.valid) begin
            state_q <= IDLE;
            cnt_q   <= '0;
          end else if (cnt_q == CntLast) begin
            state_q <= RESP;
            cnt_q   <= '0;
            dresp_q <= resp_d;
          end else begin
            cnt_q <= cnt_q - CntLast;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign dresp = dresp_q;

  // size is part of the bus protocol but carries no meaning for a whole-word memory
  logic unused_size;
  assign unused_size = ^dreq.size;

endmodule

// File: tb/tb_dbus_sram_responder.sv
module tb_dbus_sram_responder;
  import dbus_sram_responder_pkg::*;

  localparam int unsigned DEPTH = 64;
  localparam logic [63:0] BASE  = MEM_BASE;
  localparam logic [63:0] LIMIT = BASE + 64'(8 * DEPTH);

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  dbus_req_t  dreq_a = '0;
  dbus_req_t  dreq_b = '0;
  dbus_resp_t dresp_a;
  dbus_resp_t dresp_b;

  int tests_run = 0;
  int tests_failed = 0;

  // Reference contents of DUT A (LATENCY 2) and DUT B (LATENCY 1)
  logic [63:0] model_a [DEPTH];
  logic [63:0] model_b [DEPTH];

  always #5 clk = ~clk;

  dbus_sram_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (2),
    .BASE    (BASE)
  ) u_dut_a (
    .clk   (clk),
    .reset (reset),
    .dreq  (dreq_a),
    .dresp (dresp_a)
  );

  dbus_sram_responder #(
    .DEPTH   (DEPTH),
    .LATENCY (1),
    .BASE    (BASE)
  ) u_dut_b (
    .clk   (clk),
    .reset (reset),
    .dreq  (dreq_b),
    .dresp (dresp_b)
  );

  // ---------------- reference model ----------------
  function automatic bit in_range(input logic [63:0] addr);
    return (addr >= BASE) && (addr < LIMIT);
  endfunction

  function automatic int word_of(input logic [63:0] addr);
    return int'((addr - BASE) / 64'd8);
  endfunction

  function automatic logic [63:0] merge(input logic [63:0] old_w, input logic [63:0] new_w,
                                        input logic [7:0] strobe);
    logic [63:0] r;
    r = old_w;
    for (int i = 0; i < 8; i++) if (strobe[i]) r[8*i +: 8] = new_w[8*i +: 8];
    return r;
  endfunction

  function automatic logic [63:0] expect_a(input logic [63:0] addr);
    return in_range(addr) ? model_a[word_of(addr)] : 64'd0;
  endfunction

  function automatic void commit_a(input logic [63:0] addr, input logic [7:0] strobe,
                                   input logic [63:0] data);
    if (in_range(addr) && strobe != 8'd0) model_a[word_of(addr)] =
        merge(model_a[word_of(addr)], data, strobe);
  endfunction

  // ---------------- bus driver ----------------
  // Called 1 time unit after a rising edge with the DUT idle. Returns the number of edges
  // until data_ok (-1 on timeout), the returned data, addr_ok at that cycle, and whether any
  // output was non-zero before data_ok. Leaves the DUT idle again.
  task automatic run_txn(input bit use_b, input logic [63:0] addr, input logic [7:0] strobe,
                         input logic [63:0] data, output logic [63:0] rdata, output int lat,
                         output logic aok, output bit quiet);
    dbus_req_t  r;
    dbus_resp_t s;
    bit got;
    r = '{valid: 1'b1, addr: addr, size: 3'd3, strobe: strobe, data: data};
    if (use_b) dreq_b = r; else dreq_a = r;
    lat = 0; got = 0; quiet = 1; rdata = '0; aok = 1'b0;
    while (!got && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      s = use_b ? dresp_b : dresp_a;
      if (s.data_ok) begin
        got = 1; rdata = s.data; aok = s.addr_ok;
      end else if (s.addr_ok || s.data != 64'd0) begin
        quiet = 0;
      end
    end
    if (!got) lat = -1;
    if (use_b) dreq_b = '0; else dreq_a = '0;
    @(posedge clk); #1;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    dreq_a = '{valid: 1'b1, addr: BASE, size: 3'd3, strobe: 8'h00, data: 64'd0};
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      tests_run++;
      if (dresp_a !== '0 || dresp_b !== '0) begin
        tests_failed++;
        $display("FAIL reset_outputs: got a=%h b=%h required 0", dresp_a, dresp_b);
      end
    end
    dreq_a = '0;
    reset = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_init_and_preload();
    logic [63:0] rd;
    logic [63:0] w;
    int lat;
    logic aok;
    bit quiet;
    for (int i = 0; i < DEPTH; i++) begin
      w = {$urandom, $urandom};
      run_txn(0, BASE + 64'(8 * i), 8'hFF, w, rd, lat, aok, quiet);
      model_a[i] = w;
      tests_run++;
      if (lat != 2) begin
        tests_failed++;
        $display("FAIL init_store_latency[%0d]: got %0d required 2", i, lat);
      end
    end
    run_txn(0, BASE, 8'hFF, 64'h1122_3344_5566_7788, rd, lat, aok, quiet);
    commit_a(BASE, 8'hFF, 64'h1122_3344_5566_7788);
    run_txn(0, 64'h8000_0000, 8'h00, 64'd0, rd, lat, aok, quiet);
    tests_run++;
    if (lat != 2 || !quiet || aok !== 1'b1) begin
      tests_failed++;
      $display("FAIL preload_latency: got lat=%0d quiet=%0d addr_ok=%b required 2/1/1",
               lat, quiet, aok);
    end
    tests_run++;
    if (rd !== 64'h1122_3344_5566_7788) begin
      tests_failed++;
      $display("FAIL preload_data: got %h required 1122334455667788", rd);
    end
  endtask

  task automatic test_partial_store();
    logic [63:0] rd;
    int lat;
    logic aok;
    bit quiet;
    run_txn(0, 64'h8000_0008, 8'hFF, 64'd0, rd, lat, aok, quiet);
    commit_a(64'h8000_0008, 8'hFF, 64'd0);
    run_txn(0, 64'h8000_0008, 8'h0F, 64'hFFFF_FFFF_AAAA_BBBB, rd, lat, aok, quiet);
    tests_run++;
    if (rd !== 64'd0 || lat != 2) begin
      tests_failed++;
      $display("FAIL store_prewrite: got data=%h lat=%0d required 0/2", rd, lat);
    end
    commit_a(64'h8000_0008, 8'h0F, 64'hFFFF_FFFF_AAAA_BBBB);
    run_txn(0, 64'h8000_0008, 8'h00, 64'd0, rd, lat, aok, quiet);
    tests_run++;
    if (rd !== 64'h0000_0000_AAAA_BBBB) begin
      tests_failed++;
      $display("FAIL partial_store_load: got %h required 00000000aaaabbbb", rd);
    end
  endtask

  task automatic test_out_of_range();
    logic [63:0] rd;
    logic [63:0] oor [2];
    int lat;
    logic aok;
    bit quiet;
    oor[0] = 64'h7FFF_FFF8;
    oor[1] = LIMIT;
    for (int k = 0; k < 2; k++) begin
      run_txn(0, oor[k], 8'h00, 64'd0, rd, lat, aok, quiet);
      tests_run++;
      if (lat != 2 || aok !== 1'b1 || rd !== 64'd0) begin
        tests_failed++;
        $display("FAIL oor_load[%0d]: got lat=%0d addr_ok=%b data=%h required 2/1/0",
                 k, lat, aok, rd);
      end
      run_txn(0, oor[k], 8'hFF, {$urandom, $urandom}, rd, lat, aok, quiet);
      tests_run++;
      if (lat != 2 || rd !== 64'd0) begin
        tests_failed++;
        $display("FAIL oor_store[%0d]: got lat=%0d data=%h required 2/0", k, lat, rd);
      end
    end
    for (int i = 0; i < DEPTH; i++) begin
      run_txn(0, BASE + 64'(8 * i), 8'h00, 64'd0, rd, lat, aok, quiet);
      tests_run++;
      if (rd !== model_a[i]) begin
        tests_failed++;
        $display("FAIL oor_scan[%0d]: got %h required %h", i, rd, model_a[i]);
      end
    end
  endtask

  task automatic test_random();
    logic [63:0] rd;
    logic [63:0] addr;
    logic [63:0] data;
    logic [63:0] exp;
    logic [7:0]  strobe;
    int lat;
    logic aok;
    bit quiet;
    for (int n = 0; n < 80; n++) begin
      case ($urandom_range(0, 9))
        0:       addr = BASE - 64'(8 * $urandom_range(1, 4)) + 64'($urandom_range(0, 7));
        1:       addr = LIMIT + 64'(8 * $urandom_range(0, 4)) + 64'($urandom_range(0, 7));
        default: addr = BASE + 64'(8 * $urandom_range(0, DEPTH - 1)) +
                        64'($urandom_range(0, 7));
      endcase
      strobe = $urandom_range(0, 1) ? 8'($urandom) : 8'h00;
      data   = {$urandom, $urandom};
      exp    = expect_a(addr);
      run_txn(0, addr, strobe, data, rd, lat, aok, quiet);
      commit_a(addr, strobe, data);
      tests_run++;
      if (lat != 2 || !quiet || aok !== 1'b1 || rd !== exp) begin
        tests_failed++;
        $display("FAIL random[%0d] addr=%h strb=%h: got lat=%0d quiet=%0d aok=%b data=%h required 2/1/1/%h",
                 n, addr, strobe, lat, quiet, aok, rd, exp);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] addr;
    bit exp_ok;
    bit prev_ok;
    addr = BASE + 64'(8 * 7);
    prev_ok = 0;
    dreq_a = '{valid: 1'b1, addr: addr, size: 3'd3, strobe: 8'h00, data: 64'd0};
    for (int k = 1; k <= 12; k++) begin
      @(posedge clk); #1;
      // Accept at edge 1, response after LATENCY edges, one idle edge, accept again
      exp_ok = (k % 3) == 2;
      tests_run++;
      if (dresp_a.data_ok !== exp_ok || dresp_a.addr_ok !== exp_ok ||
          dresp_a.data !== (exp_ok ? model_a[7] : 64'd0) || (prev_ok && dresp_a.data_ok)) begin
        tests_failed++;
        $display("FAIL back_to_back[%0d]: got ok=%b/%b data=%h required ok=%b",
                 k, dresp_a.addr_ok, dresp_a.data_ok, dresp_a.data, exp_ok);
      end
      prev_ok = dresp_a.data_ok;
    end
    dreq_a = '0;
    @(posedge clk); #1;
  endtask

  task automatic test_abort();
    logic [63:0] rd;
    int lat;
    logic aok;
    bit quiet;
    bit seen;
    logic [63:0] addr;
    addr = BASE + 64'(8 * 5);
    dreq_a = '{valid: 1'b1, addr: addr, size: 3'd3, strobe: 8'hFF, data: ~model_a[5]};
    @(posedge clk); #1;
    dreq_a = '0;
    seen = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (dresp_a.data_ok || dresp_a.addr_ok) seen = 1;
    end
    tests_run++;
    if (seen) begin
      tests_failed++;
      $display("FAIL abort_no_resp: got response required none");
    end
    run_txn(0, addr, 8'h00, 64'd0, rd, lat, aok, quiet);
    tests_run++;
    if (lat != 2 || rd !== model_a[5]) begin
      tests_failed++;
      $display("FAIL abort_unchanged: got lat=%0d data=%h required 2/%h", lat, rd, model_a[5]);
    end
  endtask

  task automatic test_reset_mid_txn();
    logic [63:0] rd;
    int lat;
    logic aok;
    bit quiet;
    logic [63:0] addr;
    addr = BASE + 64'(8 * 9);
    // Reset while BUSY, valid still high
    dreq_a = '{valid: 1'b1, addr: addr, size: 3'd3, strobe: 8'hFF, data: ~model_a[9]};
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    tests_run++;
    if (dresp_a !== '0) begin
      tests_failed++;
      $display("FAIL reset_busy_out: got %h required 0", dresp_a);
    end
    reset = 1'b0;
    dreq_a = '0;
    @(posedge clk); #1;
    tests_run++;
    if (dresp_a !== '0) begin
      tests_failed++;
      $display("FAIL reset_busy_after: got %h required 0", dresp_a);
    end
    run_txn(0, addr, 8'h00, 64'd0, rd, lat, aok, quiet);
    tests_run++;
    if (lat != 2 || rd !== model_a[9]) begin
      tests_failed++;
      $display("FAIL reset_busy_word: got lat=%0d data=%h required 2/%h", lat, rd, model_a[9]);
    end
    // Reset while RESP: pending store is discarded
    dreq_a = '{valid: 1'b1, addr: addr, size: 3'd3, strobe: 8'hFF, data: ~model_a[9]};
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b1;
    tests_run++;
    if (dresp_a.data_ok !== 1'b1) begin
      tests_failed++;
      $display("FAIL reset_resp_pre: got data_ok=%b required 1", dresp_a.data_ok);
    end
    @(posedge clk); #1;
    reset = 1'b0;
    dreq_a = '0;
    tests_run++;
    if (dresp_a !== '0) begin
      tests_failed++;
      $display("FAIL reset_resp_out: got %h required 0", dresp_a);
    end
    @(posedge clk); #1;
    run_txn(0, addr, 8'h00, 64'd0, rd, lat, aok, quiet);
    tests_run++;
    if (rd !== model_a[9]) begin
      tests_failed++;
      $display("FAIL reset_resp_word: got %h required %h", rd, model_a[9]);
    end
  endtask

  task automatic test_latency1();
    logic [63:0] rd;
    logic [63:0] w;
    logic [63:0] addr;
    logic [63:0] exp;
    logic [7:0]  strobe;
    int lat;
    logic aok;
    bit quiet;
    for (int n = 0; n < 6; n++) begin
      addr = BASE + 64'(8 * n);
      w = {$urandom, $urandom};
      run_txn(1, addr, 8'hFF, w, rd, lat, aok, quiet);
      model_b[n] = w;
      tests_run++;
      if (lat != 1 || aok !== 1'b1) begin
        tests_failed++;
        $display("FAIL lat1_store[%0d]: got lat=%0d aok=%b required 1/1", n, lat, aok);
      end
      strobe = 8'($urandom);
      w = {$urandom, $urandom};
      run_txn(1, addr, strobe, w, rd, lat, aok, quiet);
      model_b[n] = merge(model_b[n], w, strobe);
      run_txn(1, addr + 64'($urandom_range(0, 7)), 8'h00, 64'd0, rd, lat, aok, quiet);
      exp = model_b[n];
      tests_run++;
      if (lat != 1 || !quiet || rd !== exp) begin
        tests_failed++;
        $display("FAIL lat1_load[%0d]: got lat=%0d quiet=%0d data=%h required 1/1/%h",
                 n, lat, quiet, rd, exp);
      end
    end
    run_txn(1, LIMIT, 8'h00, 64'd0, rd, lat, aok, quiet);
    tests_run++;
    if (lat != 1 || rd !== 64'd0) begin
      tests_failed++;
      $display("FAIL lat1_oor: got lat=%0d data=%h required 1/0", lat, rd);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_init_and_preload();
    test_partial_store();
    test_out_of_range();
    test_random();
    test_back_to_back();
    test_abort();
    test_reset_mid_txn();
    test_latency1();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
